// File: rtl/rotate_right.sv
// rotate_right: registered log-stage barrel right-rotator with valid flag.
// Define ROTATE_RIGHT_PIPE_EN to add a mid-network pipeline register (2-cycle latency).
module rotate_right #(
  parameter int OPERAND_WIDTH = 16,
  parameter int SHAMT_WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [OPERAND_WIDTH-1:0] In,
  input  logic [SHAMT_WIDTH-1:0]   ShAmt,
  input  logic                     in_valid,
  output logic [OPERAND_WIDTH-1:0] result,
  output logic                     out_valid
);
  localparam int W = OPERAND_WIDTH;
  localparam int S = $clog2(W);
  localparam int P = S / 2;
  logic [W-1:0] st [S+1];
  logic [W-1:0] mid;
  logic [S-1:0] n, n_hi;
  logic v_hi;
  assign n = S'(ShAmt % W);
  assign st[0] = In;
`ifdef ROTATE_RIGHT_PIPE_EN
  logic [W-1:0] p_d;
  logic [S-1:0] p_n;
  logic p_v;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      p_d <= '0;
      p_n <= '0;
      p_v <= 1'b0;
    end else begin
      p_v <= in_valid;
      if (in_valid) begin
        p_d <= st[P];
        p_n <= n;
      end
    end
  assign mid = p_d;
  assign n_hi = p_n;
  assign v_hi = p_v;
`else
  assign mid = st[P];
  assign n_hi = n;
  assign v_hi = in_valid;
`endif
  // stages at or beyond P read the (optionally registered) partial result and amount
  for (genvar k = 0; k < S; k++) begin : g_stage
    localparam int A = 2 ** k;
    logic [W-1:0] x;
    logic b;
    assign x = (k == P) ? mid : st[k];
    assign b = (k >= P) ? n_hi[k] : n[k];
    assign st[k+1] = b ? {x[A-1:0], x[W-1:A]} : x;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      result <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= v_hi;
      if (v_hi) result <= st[S];
    end
endmodule

// File: tb/tb_rotate_right.sv
// tb_rotate_right: table vectors, corner sequences and random ops checked through a scoreboard.
module tb_rotate_right;
  localparam int W = 16, SW = 4;
`ifdef ROTATE_RIGHT_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  typedef struct {
    logic [W-1:0]  a;
    logic [SW-1:0] s;
    logic [W-1:0]  e;
  } vec_t;
  logic clk = 1'b0, rst = 1'b0, in_valid = 1'b0;
  logic [W-1:0] in_d = '0, result;
  logic [SW-1:0] sh = '0;
  logic out_valid;
  int n_cmp = 0, n_err = 0;
  logic [W-1:0] q [$];
  vec_t tbl [9];
  rotate_right #(.OPERAND_WIDTH(W), .SHAMT_WIDTH(SW)) dut (
    .clk(clk), .rst(rst), .In(in_d), .ShAmt(sh), .in_valid(in_valid),
    .result(result), .out_valid(out_valid)
  );
  always #5 clk = ~clk;
  function automatic logic [W-1:0] ref_rot(input logic [W-1:0] a, input logic [SW-1:0] s);
    int n;
    n = int'(s) % W;
    for (int i = 0; i < W; i++) ref_rot[i] = a[(i + n) % W];
  endfunction
  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic drive(input logic v, input logic [W-1:0] a, input logic [SW-1:0] s, input logic [W-1:0] e);
    @(posedge clk);
    #1;
    in_valid = v;
    in_d = a;
    sh = s;
    if (v) q.push_back(e);
  endtask
  always @(negedge clk)
    if (!rst && out_valid) begin
      n_cmp++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_valid: got out_valid=1 result=%h expected no pulse", result);
      end else begin
        logic [W-1:0] e;
        e = q.pop_front();
        if (result !== e) begin
          n_err++;
          $display("FAIL scoreboard: got %h expected %h", result, e);
        end
      end
    end
  initial begin
    tbl[0] = '{16'hB38F, 4'd0,  16'hB38F};
    tbl[1] = '{16'hB38F, 4'd1,  16'hD9C7};
    tbl[2] = '{16'hB38F, 4'd2,  16'hECE3};
    tbl[3] = '{16'hB38F, 4'd4,  16'hFB38};
    tbl[4] = '{16'hB38F, 4'd8,  16'h8FB3};
    tbl[5] = '{16'hB38F, 4'd15, 16'h671F};
    tbl[6] = '{16'h0001, 4'd1,  16'h8000};
    tbl[7] = '{16'h0000, 4'd7,  16'h0000};
    tbl[8] = '{16'h8000, 4'd15, 16'h0001};
    #2 rst = 1'b1;
    #1;
    check("reset_result", result, '0);
    check("reset_valid", {15'd0, out_valid}, '0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    foreach (tbl[i]) drive(1'b1, tbl[i].a, tbl[i].s, tbl[i].e);
    drive(1'b0, 16'hFFFF, 4'd3, '0);
    repeat (LAT + 2) @(posedge clk);
    @(negedge clk);
    check("hold_result", result, 16'h0001);
    check("hold_valid", {15'd0, out_valid}, '0);
    drive(1'b1, 16'h1234, 4'd3, ref_rot(16'h1234, 4'd3));
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("midop_reset_result", result, '0);
    check("midop_reset_valid", {15'd0, out_valid}, '0);
    q.delete();
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (4) @(negedge clk);
    check("post_reset_result", result, '0);
    check("post_reset_valid", {15'd0, out_valid}, '0);
    for (int i = 0; i < 1000; i++) begin
      logic [W-1:0] a;
      logic v;
      a = W'($urandom);
      v = ($urandom_range(0, 9) != 0);
      drive(v, a, SW'(i % 16), ref_rot(a, SW'(i % 16)));
    end
    drive(1'b0, '0, '0, '0);
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    check("drain_left", W'(q.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/rotate_right.md
# rotate_right

Registered parameterizable right-rotator for the datapath's shift/rotate unit. It rotates an OPERAND_WIDTH-bit operand right by a ShAmt-bit amount. Bits shifted out of the LSB re-enter at the MSB. The result is captured in an output register with a valid flag, so it can sit directly behind the ALU operand muxes.

## Interface
- OPERAND_WIDTH, default 16: operand and result width; minimum 2.
- SHAMT_WIDTH, default 4: rotate-amount width; minimum 1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset; asynchronous, active-high.
- In  input  OPERAND_WIDTH  operand to rotate.
- ShAmt  input  SHAMT_WIDTH  unsigned rotate-right amount.
- in_valid  input  1  In/ShAmt are valid this cycle.
- result  output  OPERAND_WIDTH  rotated operand, registered.
- out_valid  output  1  result holds a newly computed value.

## Operation
- Effective amount: n = ShAmt mod OPERAND_WIDTH. Values at or above OPERAND_WIDTH are reduced this way; they are legal and must not be flagged as errors.
- Rotation: result[i] = In[(i + n) mod OPERAND_WIDTH] for every i.
- n = 0: result = In.
- n = OPERAND_WIDTH-1 is equivalent to a rotate left by 1.
- Structure: log-stage barrel network.
  - Stage k conditionally rotates by 2^k when bit k of n is set.
  - There are ceil(log2(OPERAND_WIDTH)) stages.
- All datapath arithmetic is unsigned and no bits are lost. popcount(result) = popcount(In) always.
- Input acceptance:
  - in_valid=1 at a rising edge: the rotation of the current In/ShAmt is loaded into result.
  - in_valid=0 at a rising edge: result holds its previous value.
- The block has no backpressure. Every accepted input produces exactly one out_valid pulse.

## Timing
- Latency is 1 cycle from an accepting edge to the result, with the feature in Configuration disabled.
  - Inputs sampled at edge t appear on result after edge t.
  - out_valid is 1 for the cycle following edge t.
- Throughput is one operation per cycle; back-to-back in_valid produces back-to-back out_valid.
- out_valid is the in_valid registered along the same pipeline path; it is high for exactly one cycle per accepted input.
- Reset values: result = 0 and out_valid = 0, applied immediately on rst assertion regardless of clk.
- Reset mid-operation: any in-flight operation is discarded and produces no out_valid pulse.
- First acceptance: the first edge with rst low and in_valid high loads result.

## Configuration
- Macro: ROTATE_RIGHT_PIPE_EN.
- Defined:
  - A pipeline register is inserted after stage floor(stages/2) of the barrel network, carrying the partial result, the remaining ShAmt bits and the valid flag.
  - Latency becomes 2 cycles; throughput stays one per cycle.
  - The pipeline register resets to 0 with valid = 0.
  - in_valid=0 inserts a bubble, and result/out_valid behave as above at the output stage.
- Undefined: single output register only, with 1-cycle latency.
- Functional results are identical in both builds; only latency differs.

## Test plan
- Rotate by 0: In=0xB38F, ShAmt=0, in_valid=1 -> result=0xB38F, out_valid=1 after the latency.
- Small amounts on In=0xB38F:
  - ShAmt=1 -> 0xD9C7
  - ShAmt=2 -> 0xECE3
  - ShAmt=4 -> 0xFB38
  - ShAmt=8 -> 0x8FB3
  - Issue all back-to-back; a contiguous out_valid train must appear in order.
- Maximum amount: In=0xB38F, ShAmt=15 -> 0x671F (equal to rotate left by 1).
- Hold: after the last accepted op, drive in_valid=0 with In=0xFFFF -> result unchanged, out_valid=0.
- Reset: assert rst asynchronously between clock edges while an op is in flight -> result=0 and out_valid=0 immediately, and no stale out_valid after rst deasserts.
- Exhaustive: all 16 ShAmt values × random In for 1000 cycles against the reference formula, in both ROTATE_RIGHT_PIPE_EN builds.
